// File: rtl/fp_misc_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fp_misc_arbiter
// Brief    : Two-requester round-robin front end for a shared single-precision
//            misc FP stage (FCLASS/FMIN/FMAX/FSGNJ/FSGNJN/FSGNJX) with a
//            one-entry valid/ready result register.
// Revision : 1.0 - initial release
// ============================================================================
module fp_misc_arbiter #(
    parameter int TAG_W = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [1:0][2:0]        req_op,
    input  logic [1:0][31:0]       req_in1,
    input  logic [1:0][31:0]       req_in2,
    input  logic [1:0][TAG_W-1:0]  req_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_result,
    output logic [4:0]             out_fflags,
    output logic                   out_id,
    output logic [TAG_W-1:0]       out_tag
);

    localparam logic [2:0]  c_OP_FCLASS = 3'd0;
    localparam logic [2:0]  c_OP_FMIN   = 3'd1;
    localparam logic [2:0]  c_OP_FMAX   = 3'd2;
    localparam logic [2:0]  c_OP_FSGNJ  = 3'd3;
    localparam logic [2:0]  c_OP_FSGNJN = 3'd4;
    localparam logic [2:0]  c_OP_FSGNJX = 3'd5;
    localparam logic [31:0] c_QNAN      = 32'h7FC0_0000;

    logic                  r_valid;
    logic [31:0]           r_result;
    logic [4:0]            r_fflags;
    logic                  r_id;
    logic [TAG_W-1:0]      r_tag;
    logic                  r_last;     // index granted most recently

    logic                  w_can_acc;
    logic [1:0]            w_grant;
    logic                  w_xfer;
    logic                  w_sel;
    logic [2:0]            w_op;
    logic [31:0]           w_a;
    logic [31:0]           w_b;
    logic                  w_a_nan;
    logic                  w_b_nan;
    logic                  w_a_snan;
    logic                  w_b_snan;
    logic [31:0]           w_res;
    logic [4:0]            w_flags;

    // FCLASS one-hot mask for a single-precision value
    function automatic logic [9:0] f_class(input logic [31:0] v);
        logic       s;
        logic [7:0] e;
        logic       mz;
        s  = v[31];
        e  = v[30:23];
        mz = (v[22:0] == 23'd0);
        f_class = '0;
        if (e == 8'hFF) begin
            if (mz)          f_class[s ? 0 : 7] = 1'b1;
            else if (v[22])  f_class[9] = 1'b1;
            else             f_class[8] = 1'b1;
        end else if (e == 8'h00) begin
            if (mz)          f_class[s ? 3 : 4] = 1'b1;
            else             f_class[s ? 2 : 5] = 1'b1;
        end else begin
            f_class[s ? 1 : 6] = 1'b1;
        end
    endfunction

    // Strict a < b for non-NaN operands; sign-magnitude order puts -0 below +0
    function automatic logic f_lt(input logic [31:0] a, input logic [31:0] b);
        if (a[31] != b[31]) f_lt = a[31];
        else if (!a[31])    f_lt = (a[30:0] < b[30:0]);
        else                f_lt = (a[30:0] > b[30:0]);
    endfunction

    // Round-robin grant; gated by result-register space and by reset
    always_comb begin
        w_can_acc = !r_valid || out_ready;
        w_grant   = 2'b00;
        if (!rst && w_can_acc) begin
            case (req_valid)
                2'b01:   w_grant = 2'b01;
                2'b10:   w_grant = 2'b10;
                2'b11:   w_grant = r_last ? 2'b01 : 2'b10;
                default: w_grant = 2'b00;
            endcase
        end
    end

    assign req_ready = w_grant;
    assign w_xfer    = |(req_valid & w_grant);
    assign w_sel     = w_grant[1];

    // Operand mux and misc-op datapath for the granted requester
    always_comb begin
        w_op     = req_op[w_sel];
        w_a      = req_in1[w_sel];
        w_b      = req_in2[w_sel];
        w_a_nan  = (&w_a[30:23]) && (|w_a[22:0]);
        w_b_nan  = (&w_b[30:23]) && (|w_b[22:0]);
        w_a_snan = w_a_nan && !w_a[22];
        w_b_snan = w_b_nan && !w_b[22];
        w_res    = '0;
        w_flags  = '0;
        case (w_op)
            c_OP_FCLASS: w_res = {22'd0, f_class(w_a)};
            c_OP_FMIN, c_OP_FMAX: begin
                w_flags = {w_a_snan || w_b_snan, 4'b0000};
                if (w_a_nan && w_b_nan)  w_res = c_QNAN;
                else if (w_a_nan)        w_res = w_b;
                else if (w_b_nan)        w_res = w_a;
                else if (w_op == c_OP_FMIN)
                    w_res = f_lt(w_b, w_a) ? w_b : w_a;
                else
                    w_res = f_lt(w_a, w_b) ? w_b : w_a;
            end
            c_OP_FSGNJ:  w_res = {w_b[31], w_a[30:0]};
            c_OP_FSGNJN: w_res = {~w_b[31], w_a[30:0]};
            c_OP_FSGNJX: w_res = {w_a[31] ^ w_b[31], w_a[30:0]};
            default:     w_res = '0;
        endcase
    end

    // Result register and round-robin pointer; reset drops any pending result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_result <= '0;
            r_fflags <= '0;
            r_id     <= 1'b0;
            r_tag    <= '0;
            r_last   <= 1'b1;
        end else if (w_xfer) begin
            r_valid  <= 1'b1;
            r_result <= w_res;
            r_fflags <= w_flags;
            r_id     <= w_sel;
            r_tag    <= req_tag[w_sel];
            r_last   <= w_sel;
        end else if (out_ready) begin
            r_valid  <= 1'b0;
        end
    end

    assign out_valid  = r_valid;
    assign out_result = r_result;
    assign out_fflags = r_fflags;
    assign out_id     = r_id;
    assign out_tag    = r_tag;

endmodule
`default_nettype wire

// File: tb/tb_fp_misc_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_misc_arbiter
// Brief    : Self-checking bench for fp_misc_arbiter: directed scenarios plus
//            randomized traffic against a value-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_misc_arbiter;

    localparam int TAG_W = 5;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [1:0]            req_valid;
    logic [1:0]            req_ready;
    logic [1:0][2:0]       req_op;
    logic [1:0][31:0]      req_in1;
    logic [1:0][31:0]      req_in2;
    logic [1:0][TAG_W-1:0] req_tag;
    logic                  out_valid;
    logic                  out_ready;
    logic [31:0]           out_result;
    logic [4:0]            out_fflags;
    logic                  out_id;
    logic [TAG_W-1:0]      out_tag;

    int total = 0;
    int bad   = 0;

    // reference state
    logic             m_valid;
    logic [31:0]      m_res;
    logic [4:0]       m_flg;
    logic             m_id;
    logic [TAG_W-1:0] m_tag;
    int               m_last;
    logic [1:0]       m_ready;

    fp_misc_arbiter #(.TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_in1    (req_in1),
        .req_in2    (req_in2),
        .req_tag    (req_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_fflags (out_fflags),
        .out_id     (out_id),
        .out_tag    (out_tag)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Numeric ordering key: -0 -> -1, +0 -> 0, magnitudes interleaved by sign
    function automatic longint ord_key(input logic [31:0] v);
        longint mag;
        mag = longint'(v[30:0]);
        return v[31] ? -(2 * mag + 1) : 2 * mag;
    endfunction

    function automatic bit is_nan(input logic [31:0] v);
        return (v[30:23] == 8'hFF) && (v[22:0] != 0);
    endfunction

    // Returns {fflags, result}
    function automatic logic [36:0] ref_exec(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int k;
        logic [31:0] r;
        logic [4:0]  f;
        r = 0; f = 0;
        case (op)
            3'd0: begin
                if (a[30:23] == 8'hFF)      k = (a[22:0] == 0) ? (a[31] ? 0 : 7) : (a[22] ? 9 : 8);
                else if (a[30:23] == 8'h00) k = (a[22:0] == 0) ? (a[31] ? 3 : 4) : (a[31] ? 2 : 5);
                else                        k = a[31] ? 1 : 6;
                r = 32'd1 << k;
            end
            3'd1, 3'd2: begin
                if ((is_nan(a) && !a[22]) || (is_nan(b) && !b[22])) f = 5'h10;
                if (is_nan(a) && is_nan(b)) r = 32'h7FC00000;
                else if (is_nan(a))         r = b;
                else if (is_nan(b))         r = a;
                else if (op == 3'd1)        r = (ord_key(b) < ord_key(a)) ? b : a;
                else                        r = (ord_key(b) > ord_key(a)) ? b : a;
            end
            3'd3: r = {b[31], a[30:0]};
            3'd4: r = {~b[31], a[30:0]};
            3'd5: r = {a[31] ^ b[31], a[30:0]};
            default: r = 0;
        endcase
        return {f, r};
    endfunction

    task automatic model_reset();
        m_valid = 0; m_res = 0; m_flg = 0; m_id = 0; m_tag = 0; m_last = 1; m_ready = 0;
    endtask

    // Called at a falling edge with inputs driven: check, predict next edge, advance
    task automatic step();
        int g;
        logic [36:0] fr;
        #1;
        g = -1;
        if (!m_valid || out_ready) begin
            case (req_valid)
                2'b01: g = 0;
                2'b10: g = 1;
                2'b11: g = (m_last == 0) ? 1 : 0;
                default: g = -1;
            endcase
        end
        m_ready = (g < 0) ? 2'b00 : (2'b01 << g);
        check_eq("req_ready", req_ready, m_ready);
        check_eq("out_valid", out_valid, m_valid);
        if (m_valid) begin
            check_eq("out_result", out_result, m_res);
            check_eq("out_fflags", out_fflags, m_flg);
            check_eq("out_id", out_id, m_id);
            check_eq("out_tag", out_tag, m_tag);
        end
        if (g >= 0) begin
            fr = ref_exec(req_op[g], req_in1[g], req_in2[g]);
            m_res = fr[31:0]; m_flg = fr[36:32];
            m_valid = 1; m_id = g[0]; m_tag = req_tag[g]; m_last = g;
        end else if (out_ready) begin
            m_valid = 0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input int i, input logic v, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] t);
        req_valid[i] = v; req_op[i] = op; req_in1[i] = a; req_in2[i] = b; req_tag[i] = t;
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] pool [12];
        pool = '{32'h0, 32'h80000000, 32'h7F800000, 32'hFF800000, 32'h7FC00000,
                 32'h7F800001, 32'hFFC00001, 32'h00000001, 32'h807FFFFF,
                 32'h3F800000, 32'hBF800000, 32'h3F800001};
        if ($urandom_range(0, 1) == 0) return pool[$urandom_range(0, 11)];
        return $urandom;
    endfunction

    initial begin
        rst = 1; out_ready = 1; req_valid = 0; req_op = 0;
        req_in1 = 0; req_in2 = 0; req_tag = 0;
        model_reset();
        req_valid = 2'b11;
        @(negedge clk); @(negedge clk);
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_ready", req_ready, 0);
        check_eq("rst_result", out_result, 0);
        check_eq("rst_fields", {out_fflags, out_id, out_tag}, 0);
        req_valid = 0;
        rst = 0;
        @(negedge clk);

        // single FCLASS of -inf
        drive(0, 1, 3'd0, 32'hFF800000, 32'h0, 5'd3);
        step();
        req_valid = 0;
        check_eq("tp_fclass_v", out_valid, 1);
        check_eq("tp_fclass_r", out_result, 32'h1);
        check_eq("tp_fclass_id", {out_id, out_tag}, {1'b0, 5'd3});
        check_eq("tp_fclass_f", out_fflags, 0);

        drive(1, 1, 3'd1, 32'h7F800001, 32'h3F800000, 5'd7);
        step();
        check_eq("tp_fmin_snan", out_result, 32'h3F800000);
        check_eq("tp_fmin_nv", out_fflags, 5'h10);
        check_eq("tp_fmin_id", out_id, 1);
        drive(1, 1, 3'd2, 32'h80000000, 32'h00000000, 5'd8);
        step();
        req_valid = 0;
        check_eq("tp_fmax_zero", out_result, 32'h0);
        check_eq("tp_fmax_f", out_fflags, 0);

        // contention: alternating grants, back-to-back results
        drive(0, 1, 3'd3, 32'h40000000, 32'h80000000, 5'd1);
        drive(1, 1, 3'd4, 32'h40400000, 32'h80000000, 5'd2);
        for (int n = 0; n < 4; n++) begin
            step();
            check_eq("rr_id", out_id, n % 2);
            check_eq("rr_valid", out_valid, 1);
        end
        req_valid = 0;

        // stall with pending result, then consume+accept in one cycle
        drive(0, 1, 3'd3, 32'h3F800000, 32'h0, 5'd4);
        step();
        out_ready = 0;
        drive(0, 1, 3'd0, 32'h0, 32'h0, 5'd5);
        for (int n = 0; n < 3; n++) begin
            step();
            check_eq("stall_res", out_result, 32'h3F800000);
        end
        out_ready = 1;
        step();
        req_valid = 0;
        check_eq("consume_acc_v", out_valid, 1);
        check_eq("consume_acc_r", out_result, 32'h10);

        drive(0, 1, 3'd5, 32'hBF800000, 32'h80000000, 5'd6);
        step();
        check_eq("tp_fsgnjx", out_result, 32'h3F800000);
        drive(0, 1, 3'd2, 32'h7FC00000, 32'h7FC12345, 5'd6);
        step();
        check_eq("tp_fmax_qnan", out_result, 32'h7FC00000);
        check_eq("tp_fmax_qnan_f", out_fflags, 0);
        drive(0, 1, 3'd7, 32'h3F800000, 32'h3F800000, 5'd9);
        step();
        check_eq("tp_illegal", {out_fflags, out_result}, 0);

        // asynchronous reset with a stalled result
        out_ready = 0;
        req_valid = 0;
        step();
        req_valid = 2'b11;
        rst = 1;
        #1;
        check_eq("async_rst_v", out_valid, 0);
        check_eq("async_rst_rdy", req_ready, 0);
        model_reset();
        @(negedge clk);
        rst = 0;
        out_ready = 1;
        #1;
        check_eq("rst_first_grant", req_ready, 2'b01);
        step();

        // randomized traffic honouring the hold-while-stalled rule
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!(req_valid[i] && !m_ready[i])) begin
                    drive(i, ($urandom_range(0, 2) != 0), 3'($urandom_range(0, 7)),
                          rand_operand(), rand_operand(), TAG_W'($urandom));
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
